// File: rtl/ctr_seq_pkg.sv
// Shared types and default sizing for the CTR stream sequencer.
package ctr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_KEY,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_IDX_WIDTH  = 32;
  localparam int DEF_ENCR_LAT   = 31;
  localparam int DEF_OUT_DEPTH  = 32;
  localparam int DEF_PT_DEPTH   = 32;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset and show-ahead read data.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; count gates every observable read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ctr_stream_sequencer.sv
// CTR front-end: buffers data, issues iv+index to a fixed-latency core, XORs keystream
// back onto the buffered data and streams the result out under a credit scheme.
module ctr_stream_sequencer
  import ctr_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
  parameter int ENCR_LAT   = DEF_ENCR_LAT,
  parameter int OUT_DEPTH  = DEF_OUT_DEPTH,
  parameter int PT_DEPTH   = DEF_PT_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [IDX_WIDTH-1:0]  frame_len,
  input  logic [DATA_WIDTH-1:0] iv,
  input  logic                  key_done,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  core_tvalid,
  output logic [DATA_WIDTH-1:0] core_counter,
  input  logic                  core_valid,
  input  logic [DATA_WIDTH-1:0] core_keystream,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  frame_done,
  output logic                  err
);
  localparam int CW = $clog2(OUT_DEPTH + 1);

  if (PT_DEPTH < OUT_DEPTH || ENCR_LAT < 1) begin : g_bad_params
    $error("ctr_stream_sequencer: PT_DEPTH must cover OUT_DEPTH and ENCR_LAT must be positive");
  end

  state_t                state;
  logic                  key_ready;
  logic [IDX_WIDTH-1:0]  idx, len_r;
  logic [DATA_WIDTH-1:0] iv_r;
  logic [CW-1:0]         credits;
  logic                  pt_empty, pt_full, out_empty, out_full;
  logic [DATA_WIDTH:0]   pt_rdata, out_rdata;
  logic                  accept, last_blk, ks_take, pt_pop, out_push, pop;

  // A credit is one reserved output FIFO slot, held from accept until the block leaves.
  assign s_tready = (state == RUN) && (credits != '0) && !pt_full;
  assign accept   = s_tvalid && s_tready;
  assign last_blk = (idx == len_r - IDX_WIDTH'(1));
  assign ks_take  = core_valid && (state == RUN || state == DRAIN);
  assign pt_pop   = ks_take && !pt_empty;
  assign out_push = pt_pop && !out_full;
  assign m_tvalid = !out_empty;
  assign m_tdata  = m_tvalid ? out_rdata[DATA_WIDTH-1:0] : '0;
  assign m_tlast  = m_tvalid && out_rdata[DATA_WIDTH];
  assign pop      = m_tvalid && m_tready;

  sync_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(PT_DEPTH)) u_pt_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .pop     (pt_pop),
    .wdata   ({last_blk, s_tdata}),
    .rdata   (pt_rdata),
    .empty   (pt_empty),
    .full    (pt_full)
  );

  sync_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (out_push),
    .pop     (pop),
    .wdata   ({pt_rdata[DATA_WIDTH], pt_rdata[DATA_WIDTH-1:0] ^ core_keystream}),
    .rdata   (out_rdata),
    .empty   (out_empty),
    .full    (out_full)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      key_ready  <= 1'b0;
      idx        <= '0;
      len_r      <= '0;
      iv_r       <= '0;
      frame_done <= 1'b0;
    end else begin
      if (key_done) key_ready <= 1'b1;
      frame_done <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          len_r <= frame_len;
          iv_r  <= iv;
          idx   <= '0;
          if (frame_len == '0) state <= DONE;
          else                 state <= key_ready ? RUN : WAIT_KEY;
        end
        WAIT_KEY: if (key_ready || key_done) state <= RUN;
        RUN: if (accept) begin
          idx <= idx + IDX_WIDTH'(1);
          if (last_blk) state <= DRAIN;
        end
        DRAIN: if (pt_empty && out_empty && !m_tvalid) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      credits      <= CW'(OUT_DEPTH);
      core_tvalid  <= 1'b0;
      core_counter <= '0;
      err          <= 1'b0;
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
      core_tvalid <= accept;
      if (accept) core_counter <= iv_r + DATA_WIDTH'(idx);
      // Keystream with no matching data means the core and sequencer lost lockstep.
      if (ks_take && pt_empty) err <= 1'b1;
    end
  end

endmodule
